// File: rtl/alu_pkg.sv
// Shared definitions for the modulus/ALU front-end and the downstream stage.
package alu_pkg;

  // Default operand width in bits
  localparam int DEFAULT_N = 2;

  // Loader FSM states; encoding 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    VALID = 2'd2
  } state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand bus between the switch/button source and the operand loader.
interface alu_operand_loader_if
  import alu_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = 8
);
  logic [N-1:0]     data_in;
  logic             load;
  logic             clear;
  logic [N-1:0]     dividend;
  logic [N-1:0]     divisor;
  logic             operands_valid;
  logic             sample;
  logic             div_by_zero;
  state_t           state;
  logic [CNT_W-1:0] op_count;

  // Loader side: consumes the input bus, presents the operands
  modport slave (
    input  data_in, load, clear,
    output dividend, divisor, operands_valid, sample, div_by_zero, state, op_count
  );

  // Source side: drives the input bus, observes the operands
  modport master (
    output data_in, load, clear,
    input  dividend, divisor, operands_valid, sample, div_by_zero, state, op_count
  );
endinterface

// File: rtl/edge_detector.sv
// 1-bit rising-edge detector for level inputs such as push buttons.
// A level already high when reset releases produces no edge until it has
// gone low and high again.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev_reg;
  logic armed_reg;

  // Remember last level; arm only after the first post-reset clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      prev_reg  <= level;
      armed_reg <= 1'b1;
    end
  end

  assign rise = level & ~prev_reg & armed_reg;
endmodule

// File: rtl/alu_operand_loader.sv
// Sequential operand capture for the modulus/ALU stage: dividend then divisor
// from one shared bus, then both held stable with valid/sample/zero flags.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  alu_operand_loader_if.slave bus
);
  state_t           state_reg, state_next;
  logic [N-1:0]     dividend_reg;
  logic [N-1:0]     divisor_reg;
  logic [CNT_W-1:0] count_reg;
  logic             sample_reg;
  logic             load_edge;
  logic             capture_a;
  logic             capture_b;

  edge_detector u_load_edge (
    .clk   (clk),
    .rst   (rst),
    .level (bus.load),
    .rise  (load_edge)
  );

  // Next-state and capture decode; clear overrides any load edge
  always_comb begin
    state_next = state_reg;
    capture_a  = 1'b0;
    capture_b  = 1'b0;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_edge) begin
            capture_a  = 1'b1;
            state_next = GOT_A;
          end
        end
        GOT_A: begin
          if (load_edge) begin
            capture_b  = 1'b1;
            state_next = VALID;
          end
        end
        VALID: begin
          if (load_edge) begin
            capture_a  = 1'b1;
            state_next = GOT_A;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand registers and issue counter; values survive a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      count_reg    <= '0;
    end else begin
      if (capture_a) dividend_reg <= bus.data_in;
      if (capture_b) begin
        divisor_reg <= bus.data_in;
        count_reg   <= count_reg + 1'b1;
      end
    end
  end

  // Sample strike: high only in the first cycle spent in VALID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_reg <= 1'b0;
    else     sample_reg <= (state_next == VALID) && (state_reg != VALID);
  end

  assign bus.dividend       = dividend_reg;
  assign bus.divisor        = divisor_reg;
  assign bus.operands_valid = (state_reg == VALID);
  assign bus.div_by_zero    = (state_reg == VALID) && (divisor_reg == '0);
  assign bus.sample         = sample_reg;
  assign bus.state          = state_reg;
  assign bus.op_count       = count_reg;
endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Sequential front-end for the N-bit modulus/ALU stage. Captures dividend and divisor one at a time from a single shared N-bit input bus, on successive load pulses. It then presents both operands stable, together with a valid indication and a one-cycle sample strike, so the downstream combinational modulus stage and its result register get glitch-free operands. It also flags a zero divisor early and counts issued operations.

Parameters:
N, 2, operand width in bits (must be >= 2)
CNT_W, 8, width of the issued-operation counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  N  shared operand bus (e.g. board switches), sampled on a load edge
load  input  1  level input; each 0->1 transition (detected internally) captures one operand
clear  input  1  synchronous abort; returns FSM to IDLE, drops valid
dividend  output  N  registered dividend to the downstream stage
divisor  output  N  registered divisor to the downstream stage
operands_valid  output  1  high while both operands are captured and stable
sample  output  1  one-cycle pulse on the first cycle of operands_valid
div_by_zero  output  1  high while operands_valid and divisor == 0
state  output  2  current FSM state encoding, for debug/LEDs
op_count  output  CNT_W  number of operand pairs issued, modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=IDLE, dividend=0, divisor=0, operands_valid=0, sample=0, div_by_zero=0, op_count=0, load_prev=0.
- Edge detect: load_prev <= load every cycle. load_edge = load & ~load_prev. A level held high produces exactly one edge. A load already high when reset releases produces no edge until it goes low then high.
- States (2-bit): IDLE=0, GOT_A=1, VALID=2; encoding 3 is unused and must recover to IDLE.
- IDLE: on load_edge: dividend <= data_in, go GOT_A.
- GOT_A: on load_edge: divisor <= data_in, go VALID, op_count <= op_count+1 (wraps 2^CNT_W-1 -> 0).
- VALID: operands_valid=1.
  - div_by_zero = (divisor==0), combinational from the registered divisor.
  - On load_edge: dividend <= data_in, go GOT_A. operands_valid drops in the same cycle the state leaves VALID. This is the start of a new operation.
- sample: registered. It is 1 exactly in the first cycle state==VALID, and 0 otherwise. Operands are already stable in that cycle, so latency from the 2nd load edge to sample is 1 cycle.
- clear: has priority over load_edge in every state. Next state is IDLE, operands_valid=0 next cycle. dividend, divisor and op_count are retained, not zeroed.
- Simultaneous clear and load_edge: clear wins; that load edge is consumed and captures nothing.
- operands_valid and div_by_zero are decoded from the registered state, so they change only at clock edges.
- dividend and divisor change only on a capture edge. They never change while operands_valid=1.
- No arithmetic is performed here beyond the zero compare and the counter increment.

Decomposition:
- Shared package alu_pkg: state enum (IDLE, GOT_A, VALID) as a 2-bit typedef, plus a default operand-width constant. The downstream stage reuses the same package.
- One natural sub-module: edge_detector (1-bit rising-edge detector, async active-high reset). It is reusable by other button-driven lab blocks.
- FSM, operand registers and counter stay in alu_operand_loader.

Test Plan:
- Reset mid-operation: N=4. Assert rst while in GOT_A -> all outputs 0 and state=0 asynchronously, before the next clk edge.
- Normal issue: N=4. load edge with data_in=4'd13, then load edge with data_in=4'd5 -> dividend=13, divisor=5. One cycle later: operands_valid=1, sample=1 for exactly one cycle, div_by_zero=0, op_count=1.
- Zero divisor: edges with 4'd9 then 4'd0 -> operands_valid=1, div_by_zero=1, divisor=0, sample pulses once.
- Held load: load held high for 10 cycles with data_in=4'd7 -> exactly one capture (dividend=7, state=GOT_A), divisor unchanged.
- Clear priority: in GOT_A, assert clear and a load edge in the same cycle -> state=IDLE, divisor not updated, op_count unchanged, operands_valid=0.
- Counter wrap: CNT_W=2, issue 5 complete operand pairs -> op_count sequence 1,2,3,0,1. A new load edge while VALID drops operands_valid the next cycle and captures the new dividend.
